// File: rtl/mux16_serializer_if.sv
// Bundle of the scan request, lane vector and serial beat outputs shared
// between the serializer and whatever drives and consumes it.
interface mux16_serializer_if;
    logic        start;
    logic [15:0] d;
    logic        y;
    logic [3:0]  sel;
    logic        valid;
    logic        done;
    logic        busy;

    modport master (
        output start,
        output d,
        input  y,
        input  sel,
        input  valid,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  d,
        output y,
        output sel,
        output valid,
        output done,
        output busy
    );
endinterface

// File: rtl/mux16_serializer.sv
// Snapshots a 16-lane vector on start and emits lanes 0..LAST_CH one per clock
// on a serial line, tagging each beat with its channel index.
module mux16_serializer #(
    parameter int LAST_CH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mux16_serializer_if.slave     bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] LAST_SEL = 4'(LAST_CH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_snap;
    logic [15:0] w_snap_nxt;
    logic [3:0]  r_sel;
    logic [3:0]  w_sel_nxt;
    logic        r_y;
    logic        w_y_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_last;
    logic [3:0]  w_sel_inc;

    assign w_last    = (r_sel == LAST_SEL);
    assign w_sel_inc = r_sel + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_sel   <= '0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_sel   <= w_sel_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_sel_nxt   = r_sel;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SCAN;
                    w_snap_nxt  = bus.d;
                    w_sel_nxt   = 4'd0;
                    w_y_nxt     = bus.d[0];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_sel_nxt   = 4'd0;
                    w_y_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (!w_last) begin
                    w_sel_nxt   = w_sel_inc;
                    w_y_nxt     = r_snap[w_sel_inc];
                    w_valid_nxt = 1'b1;
                end else if (bus.start) begin
                    // Last beat doubles as the accept edge so scans chain gap-free
                    w_snap_nxt  = bus.d;
                    w_sel_nxt   = 4'd0;
                    w_y_nxt     = bus.d[0];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 4'd0;
                    w_y_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 4'd0;
                w_y_nxt     = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.y     = r_y;
    assign bus.sel   = r_sel;
    assign bus.valid = r_valid;
    assign bus.busy  = r_valid;
    assign bus.done  = r_valid && w_last;

endmodule
